// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry, derived constants and FSM encoding for the conv sequencer.
// Optional feature macro: CONV_ZERO_PAD_EN ("same" convolution with zero padding).
// Contents: image/kernel parameters, derived sizes, counter widths, state_t enum.
package conv_pkg;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;
  localparam int N_FILT = 2;
  localparam int PIX_W  = 8;

  localparam int N_TAPS = K * K;
  localparam int N_PIX  = IMG_W * IMG_H;

`ifdef CONV_ZERO_PAD_EN
  localparam int OUT_W = IMG_W;
  localparam int OUT_H = IMG_H;
`else
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
`endif
  localparam int N_POS = OUT_W * OUT_H;

  localparam int ADDR_W = $clog2(N_PIX);
  localparam int POS_W  = 6;
  localparam int WIDX_W = 5;
  localparam int OX_W   = $clog2(OUT_W);
  localparam int OY_W   = $clog2(OUT_H);
  localparam int KC_W   = $clog2(K);
  localparam int FILT_W = (N_FILT > 1) ? $clog2(N_FILT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_OUT     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/conv_image_buffer.sv
// conv_image_buffer: N_PIX x PIX_W pixel store, one sync write port, one combinational read port.
// Ports: clk; we/waddr/wdata write on clk rising edge; raddr -> rdata combinational.
// Storage has no reset; contents persist until overwritten by the next load.
module conv_image_buffer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PIX_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [N_PIX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: loads an 8x8 image, then walks every tap of every filter per output position,
// driving the shared MAC, and hands each position to downstream via res_valid/res_ready.
// Ports: clk/reset (sync, active-high); start; pix_in/pix_valid/pix_ready load stream;
// mac_* MAC controls; res_valid/res_ready/pos_idx result handshake; busy; done pulse.
// Optional feature macro: CONV_ZERO_PAD_EN selects centred "same" windows with zero padding.
module conv_sequencer
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             mac_en,
  output logic             mac_clear,
  output logic [PIX_W-1:0] mac_pixel,
  output logic [4:0]       mac_widx,
  output logic             mac_filter,
  output logic             mac_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [5:0]       pos_idx,
  output logic             busy,
  output logic             done
);

  state_t              state;
  logic [ADDR_W-1:0]   load_cnt;
  logic [KC_W-1:0]     kx, ky;
  logic [FILT_W-1:0]   filt;
  logic [OX_W-1:0]     ox;
  logic [OY_W-1:0]     oy;
  logic [POS_W-1:0]    pos;

  logic [ADDR_W-1:0]   raddr;
  logic [PIX_W-1:0]    rdata;
  logic                in_img;
  logic                in_compute;
  logic                we;
  int                  ix, iy;

  assign in_compute = (state == ST_COMPUTE);
  assign we         = (state == ST_LOAD) && pix_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      load_cnt <= '0;
      kx       <= '0;
      ky       <= '0;
      filt     <= '0;
      ox       <= '0;
      oy       <= '0;
      pos      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            load_cnt <= '0;
            kx       <= '0;
            ky       <= '0;
            filt     <= '0;
            ox       <= '0;
            oy       <= '0;
            pos      <= '0;
          end
        end
        ST_LOAD: begin
          if (pix_valid) begin
            // Wraps to 0 on the final pixel, leaving the counter clean for the next frame.
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == ADDR_W'(N_PIX - 1)) state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // Tap order: kx fastest, then ky, then filter.
          if (kx == KC_W'(K - 1)) begin
            kx <= '0;
            if (ky == KC_W'(K - 1)) begin
              ky <= '0;
              if (filt == FILT_W'(N_FILT - 1)) begin
                filt  <= '0;
                state <= ST_OUT;
              end else begin
                filt <= filt + 1'b1;
              end
            end else begin
              ky <= ky + 1'b1;
            end
          end else begin
            kx <= kx + 1'b1;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            if (pos == POS_W'(N_POS - 1)) begin
              state <= ST_DONE;
            end else begin
              pos   <= pos + 1'b1;
              state <= ST_COMPUTE;
              if (ox == OX_W'(OUT_W - 1)) begin
                ox <= '0;
                oy <= oy + 1'b1;
              end else begin
                ox <= ox + 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          pos   <= '0;
          ox    <= '0;
          oy    <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Window address from registered counters, so the pixel lines up with the strobes.
  always_comb begin
    ix = int'(ox) + int'(kx);
    iy = int'(oy) + int'(ky);
`ifdef CONV_ZERO_PAD_EN
    ix = ix - K / 2;
    iy = iy - K / 2;
    in_img = (ix >= 0) && (ix < IMG_W) && (iy >= 0) && (iy < IMG_H);
`else
    in_img = 1'b1;
`endif
    raddr = in_img ? ADDR_W'(iy * IMG_W + ix) : '0;
  end

  conv_image_buffer u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (load_cnt),
    .wdata (pix_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Outputs decode directly from the state/counter registers.
  assign pix_ready  = (state == ST_LOAD);
  assign mac_en     = in_compute;
  assign mac_clear  = in_compute && (kx == '0) && (ky == '0);
  assign mac_last   = in_compute && (kx == KC_W'(K - 1)) && (ky == KC_W'(K - 1));
  assign mac_pixel  = (in_compute && in_img) ? rdata : '0;
  assign mac_widx   = in_compute ? WIDX_W'(int'(filt) * N_TAPS + int'(ky) * K + int'(kx)) : '0;
  assign mac_filter = in_compute && filt[0];
  assign res_valid  = (state == ST_OUT);
  assign pos_idx    = pos;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed frames with randomized images and load gaps, checked against a
// window-arithmetic reference model of the convolution tap walk.
// Covers reset state, ignored inputs, load stalls, result backpressure, done timing, mid-frame reset.
module tb_conv_sequencer;

  localparam int IW = 8;
  localparam int IH = 8;
  localparam int KS = 3;
  localparam int NF = 2;
`ifdef CONV_ZERO_PAD_EN
  localparam int OW   = IW;
  localparam int OH   = IH;
  localparam int HALF = KS / 2;
`else
  localparam int OW   = IW - KS + 1;
  localparam int OH   = IH - KS + 1;
  localparam int HALF = 0;
`endif
  localparam int NPOS = OW * OH;
  localparam int TAPS_PER_POS = KS * KS * NF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       mac_en, mac_clear, mac_filter, mac_last;
  logic [7:0] mac_pixel;
  logic [4:0] mac_widx;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [5:0] pos_idx;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] img [IW*IH];

  always #5 clk = ~clk;

  conv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .mac_en     (mac_en),
    .mac_clear  (mac_clear),
    .mac_pixel  (mac_pixel),
    .mac_widx   (mac_widx),
    .mac_filter (mac_filter),
    .mac_last   (mac_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .pos_idx    (pos_idx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pixel under tap t (0..K*K-1) of the window for output position p.
  function automatic logic [7:0] exp_pix(input int p, input int t);
    int x, y;
    x = (p % OW) + (t % KS) - HALF;
    y = (p / OW) + (t / KS) - HALF;
    if (x < 0 || x >= IW || y < 0 || y >= IH) return 8'd0;
    return img[y * IW + x];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_mac_en"}, mac_en, 0);
    check({tag, "_mac_clear"}, mac_clear, 0);
    check({tag, "_mac_last"}, mac_last, 0);
    check({tag, "_mac_pixel"}, mac_pixel, 0);
    check({tag, "_mac_widx"}, mac_widx, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_pos_idx"}, pos_idx, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One frame: start, load img[] (optionally with random gaps), then check every tap and handshake.
  task automatic run_frame(input bit gaps, input int stall_pos, input int abort_pos);
    int idx, guard, cyc, t;
    bit acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", busy, 1);
    check("load_pix_ready", pix_ready, 1);
    idx = 0;
    guard = 0;
    while (idx < IW * IH && guard < 4000) begin
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_in    = img[idx];
      acc       = pix_valid && pix_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    pix_valid = 1'b0;
    if (idx < IW * IH) begin
      check("load_timeout", 0, 1);
      return;
    end
    check("load_pix_ready_drop", pix_ready, 0);
    check("first_mac_en", mac_en, 1);
    cyc = 0;
    for (int p = 0; p < NPOS; p++) begin
      for (int s = 0; s < TAPS_PER_POS; s++) begin
        t = s % (KS * KS);
        if (p == abort_pos && s == 4) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check_idle_outputs("abort");
          for (int k = 0; k < 4; k++) begin
            check("abort_no_done", done, 0);
            check("abort_idle", busy, 0);
            tick();
          end
          return;
        end
        start = (p == 2 && s == 3);
        check("mac_en", mac_en, 1);
        check("mac_clear", mac_clear, t == 0);
        check("mac_last", mac_last, t == KS * KS - 1);
        check("mac_widx", mac_widx, s);
        check("mac_filter", mac_filter, s / (KS * KS));
        check("mac_pixel", mac_pixel, exp_pix(p, t));
        check("pos_idx", pos_idx, p);
        check("res_valid_low", res_valid, 0);
        check("pix_ready_low", pix_ready, 0);
        check("done_low", done, 0);
        tick();
        start = 1'b0;
        cyc++;
      end
      if (p == stall_pos) begin
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          check("stall_res_valid", res_valid, 1);
          check("stall_mac_en", mac_en, 0);
          check("stall_pos_idx", pos_idx, p);
          tick();
          cyc++;
        end
        res_ready = 1'b1;
      end
      check("out_res_valid", res_valid, 1);
      check("out_mac_en", mac_en, 0);
      check("out_pos_idx", pos_idx, p);
      tick();
      cyc++;
    end
    check("done_pulse", done, 1);
    check("done_cycle", cyc, NPOS * (TAPS_PER_POS + 1) + ((stall_pos >= 0) ? 5 : 0));
    tick();
    check("done_once", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // pix_valid in IDLE is not accepted.
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      check("idle_pix_ready", pix_ready, 0);
      check("idle_busy", busy, 0);
      tick();
    end
    pix_valid = 1'b0;

    // Frame 1: ramp image, gapless load, res_ready always high.
    for (int i = 0; i < IW * IH; i++) img[i] = 8'(i);
    run_frame(1'b0, -1, -1);
    tick();

    // Frame 2: random image, gapped load, backpressure at position 7.
    for (int i = 0; i < IW * IH; i++) img[i] = 8'($urandom);
    run_frame(1'b1, 7, -1);
    tick();

    // Frame 3: reset in the middle of position 10.
    for (int i = 0; i < IW * IH; i++) img[i] = 8'($urandom);
    run_frame(1'b1, -1, 10);

    // Frame 4: fresh load after the abort reproduces the full sequence.
    for (int i = 0; i < IW * IH; i++) img[i] = 8'($urandom);
    run_frame(1'b0, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
